// File: rtl/mem_seq_pkg.sv
// Shared types for the vector memory sequencer: FSM states, element index
// and the captured request descriptor.
package mem_seq_pkg;

  localparam int unsigned VEC_ELEMS = 20;  // elements per vector
  localparam int unsigned ELEM_W    = 8;   // element width == memory data width
  localparam int unsigned ADDR_W    = 32;  // byte address width

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_TAIL = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Must count 0..VEC_ELEMS inclusive: loads run the index one past the last
  // element so the tail capture can reuse the idx-1 slot selection.
  typedef logic [$clog2(VEC_ELEMS+1)-1:0] idx_t;

  typedef struct packed {
    logic              write;
    logic              vector;
    logic [ADDR_W-1:0] addr;
  } req_t;

endpackage

// File: rtl/vector_mem_sequencer.sv
// Serialises scalar and vector load/store requests onto a single byte-wide
// memory port. Vectors become I consecutive byte accesses starting at the
// base address (wrapping modulo 2^A); scalars become one access.
// Element k of a vector bus occupies bits [k*L +: L].
module vector_mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned I = VEC_ELEMS,
  parameter int unsigned L = ELEM_W,
  parameter int unsigned A = ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic           req_vector,
  input  logic [A-1:0]   req_addr,
  input  logic [I*L-1:0] req_wdata_vec,
  input  logic [L-1:0]   req_wdata_sca,
  output logic           resp_valid,
  output logic [I*L-1:0] resp_rdata_vec,
  output logic [L-1:0]   resp_rdata_sca,
  output logic           busy,
  output logic [A-1:0]   mem_addr,
  output logic [L-1:0]   mem_wdata,
  output logic           mem_wren,
  input  logic [L-1:0]   mem_rdata
);

  state_e         state_q, state_d;
  idx_t           idx_q, idx_d;
  idx_t           last_idx;
  idx_t           rd_elem;
  req_t           req_q;
  logic [I*L-1:0] wdata_q;
  logic [I*L-1:0] rdata_q;
  logic           accept;
  logic           capture;

  assign accept   = (state_q == IDLE) && req_valid;
  assign last_idx = req_q.vector ? idx_t'(I - 1) : '0;

  // Read data lags the issued address by one cycle, so the slot being filled
  // is always one behind the index; RD_TAIL collects the final element.
  assign capture = ((state_q == RD) && (idx_q != '0)) || (state_q == RD_TAIL);
  assign rd_elem = idx_q - 1'b1;

  // Next-state and index sequencing.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_write ? WR : RD;
          idx_d   = '0;
        end
      end
      WR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == last_idx) state_d = DONE;
      end
      RD: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == last_idx) state_d = RD_TAIL;
      end
      RD_TAIL: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and element index registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Request capture on acceptance; a scalar store parks its byte in slot 0
  // so the WR datapath is identical for both request kinds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      req_q.write  <= req_write;
      req_q.vector <= req_vector;
      req_q.addr   <= req_addr;
      wdata_q      <= req_vector ? req_wdata_vec
                                 : {{((I-1)*L){1'b0}}, req_wdata_sca};
    end
  end

  // Load result register file, one byte slot per element.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the result file is reset even though it is storage: a reset
    // mid-load must discard partial results, and the outputs read zero after
    // reset rather than stale data.
    if (!rst) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q[rd_elem*L +: L] <= mem_rdata;
    end
  end

  // Memory port drive: quiet (all zero) outside the issuing states.
  always_comb begin
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WR: begin
        // Gated by the captured write flag so a load can never strobe a store.
        mem_wren  = req_q.write;
        mem_addr  = req_q.addr + A'(idx_q);
        mem_wdata = wdata_q[idx_q*L +: L];
      end
      RD: begin
        mem_addr = req_q.addr + A'(idx_q);
      end
      default: ;
    endcase
  end

  assign req_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign resp_valid     = (state_q == DONE);
  assign resp_rdata_vec = rdata_q;
  assign resp_rdata_sca = rdata_q[L-1:0];

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer. A reference model turns each
// accepted request into an expected write stream and an expected response;
// a negedge monitor compares them against what the DUT presents.
module tb_vector_mem_sequencer;

  localparam int I  = 20;
  localparam int L  = 8;
  localparam int A  = 32;
  localparam int VW = I * L;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic          req_vector = 1'b0;
  logic [A-1:0]  req_addr = '0;
  logic [VW-1:0] req_wdata_vec = '0;
  logic [L-1:0]  req_wdata_sca = '0;
  logic          resp_valid;
  logic [VW-1:0] resp_rdata_vec;
  logic [L-1:0]  resp_rdata_sca;
  logic          busy;
  logic [A-1:0]  mem_addr;
  logic [L-1:0]  mem_wdata;
  logic          mem_wren;
  logic [L-1:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  vector_mem_sequencer #(.I(I), .L(L), .A(A)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_vector     (req_vector),
    .req_addr       (req_addr),
    .req_wdata_vec  (req_wdata_vec),
    .req_wdata_sca  (req_wdata_sca),
    .resp_valid     (resp_valid),
    .resp_rdata_vec (resp_rdata_vec),
    .resp_rdata_sca (resp_rdata_sca),
    .busy           (busy),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wren       (mem_wren),
    .mem_rdata      (mem_rdata)
  );

  // Memory environment: synchronous byte RAM, read data one cycle later.
  logic [7:0] env_mem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_wren) env_mem[mem_addr] = mem_wdata;
    mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : 8'h00;
  end

  // Reference model. Period k is the interval after clock edge k; a request
  // accepted at edge c0 writes element k in period c0+k, responds in period
  // c0+n (store) or c0+n+1 (load), and the next acceptance edge is resp+2.
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { int cyc; logic [VW-1:0] vec; } rs_t;

  logic [7:0]    ref_mem [logic [31:0]];
  wr_t           exp_wr[$];
  rs_t           exp_rs[$];
  logic [VW-1:0] model_res = '0;
  int            cyc = 0;
  int            free_at = 0;
  int            last_acc = -1;

  task automatic model_accept();
    int n;
    logic [31:0] a;
    logic [7:0] d;
    rs_t r;
    n = req_vector ? I : 1;
    last_acc = cyc;
    for (int k = 0; k < n; k++) begin
      a = req_addr + 32'(k);
      if (req_write) begin
        d = req_vector ? req_wdata_vec[k*L +: L] : req_wdata_sca;
        ref_mem[a] = d;
        exp_wr.push_back('{addr: a, data: d, cyc: cyc + k});
      end else begin
        model_res[k*L +: L] = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
      end
    end
    r.cyc = req_write ? cyc + n : cyc + n + 1;
    r.vec = model_res;
    exp_rs.push_back(r);
    free_at = r.cyc + 2;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_at   = 0;
      model_res = '0;
    end else begin
      cyc++;
      if (req_valid && cyc >= free_at) model_accept();
    end
  end

  // Monitor / scoreboard.
  int   checks = 0;
  int   errors = 0;
  int   wr_ptr = 0;
  int   rs_ptr = 0;
  logic timeout_seen = 1'b0;
  logic chk_held = 1'b0;
  logic chk_end = 1'b0;

  task automatic check(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic exp_ready;
    check("no_timeout", timeout_seen, 1'b0);
    if (!rst) begin
      check("rst_outputs",
            {resp_valid, mem_wren, busy, req_ready, mem_addr, mem_wdata},
            {1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00});
      check("rst_rdata_vec", resp_rdata_vec, '0);
      check("rst_rdata_sca", resp_rdata_sca, '0);
      wr_ptr = exp_wr.size();
      rs_ptr = exp_rs.size();
    end else begin
      exp_ready = (cyc + 1 >= free_at);
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, !exp_ready);
      if (wr_ptr < exp_wr.size() && exp_wr[wr_ptr].cyc == cyc) begin
        check("wr_wren", mem_wren, 1'b1);
        check("wr_addr", mem_addr, exp_wr[wr_ptr].addr);
        check("wr_data", mem_wdata, exp_wr[wr_ptr].data);
        wr_ptr++;
      end else begin
        check("quiet_wren", mem_wren, 1'b0);
        check("quiet_wdata", mem_wdata, 8'h00);
      end
      if (rs_ptr < exp_rs.size() && exp_rs[rs_ptr].cyc == cyc) begin
        check("resp_valid", resp_valid, 1'b1);
        check("resp_rdata_vec", resp_rdata_vec, exp_rs[rs_ptr].vec);
        check("resp_rdata_sca", resp_rdata_sca, exp_rs[rs_ptr].vec[L-1:0]);
        rs_ptr++;
      end else begin
        check("resp_quiet", resp_valid, 1'b0);
      end
      if (chk_held) begin
        check("held_rdata_vec", resp_rdata_vec, model_res);
        check("held_rdata_sca", resp_rdata_sca, model_res[L-1:0]);
      end
      if (chk_end) begin
        check("writes_drained", wr_ptr, exp_wr.size());
        check("resps_drained", rs_ptr, exp_rs.size());
      end
    end
  end

  // Stimulus.
  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input logic w, input logic v, input logic [31:0] a,
                       input logic [VW-1:0] wv, input logic [7:0] ws);
    bit ok;
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = w; req_vector = v;
    req_addr = a; req_wdata_vec = wv; req_wdata_sca = ws;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(posedge clk); #1;
      if (last_acc == cyc) ok = 1'b1;
    end
    if (!ok) timeout_seen = 1'b1;
    #1;
    // Scramble inputs after acceptance: the DUT must work from its capture.
    req_valid = 1'b0; req_addr = $urandom; req_wdata_vec = rand_vec();
    req_wdata_sca = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (cyc + 1 >= free_at) ok = 1'b1;
    end
    if (!ok) timeout_seen = 1'b1;
  endtask

  logic [VW-1:0] seq_vec;

  initial begin
    for (int k = 0; k < I; k++) seq_vec[k*L +: L] = 8'(k + 1);

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Scalar store, then a 1..20 vector store and its read-back.
    drive(1'b1, 1'b0, 32'h100, rand_vec(), 8'hA5);
    wait_idle();
    drive(1'b1, 1'b1, 32'h10, seq_vec, 8'h00);
    wait_idle();
    drive(1'b0, 1'b1, 32'h10, rand_vec(), 8'h00);
    wait_idle();
    repeat (5) @(posedge clk);
    #2 chk_held = 1'b1;
    @(posedge clk); #2 chk_held = 1'b0;

    // Address wrap across 2^32.
    drive(1'b1, 1'b1, 32'hFFFF_FFFE, rand_vec(), 8'h00);
    wait_idle();
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, rand_vec(), 8'h00);
    wait_idle();

    // Scalar load only replaces element 0.
    drive(1'b0, 1'b0, 32'h100, rand_vec(), 8'h00);
    wait_idle();

    // req_valid held high with a moving address: one transfer at a time.
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b1; req_vector = 1'b1;
    for (int t = 0; t < 30; t++) begin
      req_addr = 32'h300 + 32'($urandom_range(0, 255));
      req_wdata_vec = rand_vec();
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
    wait_idle();

    // Randomised mix, often back-to-back.
    for (int t = 0; t < 16; t++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : 32'h200 + 32'($urandom_range(0, 63)),
            rand_vec(), 8'($urandom));
    end
    wait_idle();

    // Reset during relative cycle 7 of a vector load, then a scalar load.
    drive(1'b0, 1'b1, 32'h10, rand_vec(), 8'h00);
    for (int t = 0; t < 50 && cyc < last_acc + 6; t++) @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    drive(1'b0, 1'b0, 32'h100, rand_vec(), 8'h00);
    wait_idle();

    repeat (3) @(posedge clk);
    #2 chk_end = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Sequences scalar and vector load/store requests from the memory pipeline stage onto the single byte-wide data memory port. Vector accesses are serialised into I consecutive byte accesses; scalar accesses become one byte access. A valid/ready request handshake, a one-cycle response pulse and a busy/stall output let the pipeline hold while a transfer is in flight.

## Interface
Parameters:
- I, 20, elements per vector
- L, 8, element width in bits (equals memory data width)
- A, 32, address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_vector  in  1  1 = vector (I elements), 0 = scalar
- req_addr  in  A  base byte address
- req_wdata_vec  in  I×L  store data, element k to base+k
- req_wdata_sca  in  L  scalar store data
- resp_valid  out  1  one-cycle pulse: transfer complete
- resp_rdata_vec  out  I×L  load result, element k from base+k
- resp_rdata_sca  out  L  scalar load result
- busy  out  1  state ≠ IDLE; drives pipeline stall
- mem_addr  out  A  memory address
- mem_wdata  out  L  memory write data
- mem_wren  out  1  memory write enable
- mem_rdata  in  L  memory read data, valid one cycle after mem_addr is presented

## Operation
- States: IDLE, WR, RD, RD_TAIL, DONE.
- IDLE: req_ready=1. On req_valid, capture write, vector, addr, write data; set n = vector ? I : 1; idx=0. Go to WR if write, else RD.
- WR: mem_wren=1, mem_addr=base+idx, mem_wdata = element idx (or the scalar data). idx increments each cycle; after idx==n−1 go to DONE.
- RD: mem_addr=base+idx, mem_wren=0. Each cycle with idx≥1, capture mem_rdata into result[idx−1]. After issuing idx==n−1, go to RD_TAIL.
- RD_TAIL: capture mem_rdata into result[n−1]. Go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in DONE.
- Address arithmetic: base+idx modulo 2^A. 0xFFFFFFFF+1 wraps to 0x00000000.
- resp_rdata_sca = result[0]. resp_rdata_vec and resp_rdata_sca hold their values until the next load overwrites them. A scalar load overwrites only result[0]. Stores never change the result registers.
- req_valid outside IDLE is ignored; there is no queueing.
- Outside WR: mem_wren=0 and mem_wdata=0. In IDLE and DONE: mem_addr=0.

## Timing
- Reset (async assert, sync release): state=IDLE, idx=0, result regs=0, resp_valid=0, mem_wren=0, mem_addr=0, mem_wdata=0, busy=0, req_ready=1.
- Reset mid-transfer aborts immediately: mem_wren drops asynchronously, no resp_valid is produced, and partial results are discarded (cleared).
- Accept edge = cycle 0.
- Store: WR occupies cycles 1..n; resp_valid in cycle n+1. Vector store latency is 21 cycles, scalar store 2 cycles.
- Load: RD occupies cycles 1..n, RD_TAIL cycle n+1, resp_valid in cycle n+2. Vector load latency is 22 cycles, scalar load 3 cycles.
- The next request can be accepted in the cycle after DONE.
- busy is high from cycle 1 through DONE inclusive.

## Structure
- Shared package mem_seq_pkg holds:
  - state enum typedef (IDLE, WR, RD, RD_TAIL, DONE)
  - element-index typedef sized $clog2(I+1)
  - request struct typedef (write, vector, addr)
- Single flat module. The FSM, index counter and result register file are small enough that no sub-module is warranted.

## Test plan
- Scalar store 0xA5 at 0x100 → one cycle with mem_wren=1, mem_addr=0x100, mem_wdata=0xA5; resp_valid at cycle 2.
- Vector store of elements k+1 at 0x10 → 20 consecutive writes, 0x10..0x23 with data 1..20; resp_valid at cycle 21.
- Vector load from 0x10 (after the previous store) → resp_rdata_vec[k]=k+1 for all k; resp_valid at cycle 22; results still held 5 cycles later.
- Vector store at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, …, 0x11.
- req_valid held high throughout a vector store, with changing req_addr → exactly one transfer while busy; the second request is accepted the cycle after DONE with the address present at that time.
- rst low at cycle 7 of a vector load → all outputs at their reset values in that cycle, no resp_valid, and a subsequent scalar load completes normally.
